// File: rtl/shot_turn_controller.sv
// Turn sequencer for a two-to-four player shooting game.
// Build option: define SHOT_TIMEOUT_EN to forfeit idle human turns.
`timescale 1ns/1ps
module shot_turn_controller #(
  parameter int N_PLAYERS      = 2,
  parameter int COORD_W        = 4,
  parameter int BOARD_SIZE     = 10,
  parameter int LIFE_W         = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          enter,
  input  logic                          select,
  input  logic                          mode,
  input  logic [2*COORD_W-1:0]          posicao_rnd,
  input  logic                          acertou_tiro,
  input  logic [N_PLAYERS*LIFE_W-1:0]   qtd,
  output logic                          ready,
  output logic [COORD_W-1:0]            coord_tiroX,
  output logic [COORD_W-1:0]            coord_tiroY,
  output logic [1:0]                    atacante,
  output logic [1:0]                    vencedor,
  output logic [7:0]                    LEDR,
  output logic [7:0]                    LEDG
);

  typedef enum logic [2:0] {
    ATK_X,
    ATK_Y,
    VERIF_ACERTO,
    VERIF_VIDA,
    NEXT_TURN,
    VENCEDOR,
    END_GAME
  } state_t;

  localparam logic [COORD_W-1:0] MAXC = COORD_W'(BOARD_SIZE - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic                r_enter_q;
  logic                r_select_q;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [1:0]          r_atk;
  logic [1:0]          r_win;
  logic                r_miss;
  logic                r_to_pulse;

  logic                w_ent;
  logic                w_sel;
  logic                w_cpu;
  logic                w_timeout;
  logic [3:0]          w_life4;
  logic [2:0]          w_alive;
  logic [1:0]          w_next_atk;
  logic [1:0]          w_winner;
  logic [COORD_W-1:0]  w_rnd_x;
  logic [COORD_W-1:0]  w_rnd_y;

  function automatic logic [COORD_W-1:0] f_inc(
    input logic [COORD_W-1:0] v
  );
    return (v == MAXC) ? '0 : v + 1'b1;
  endfunction

  // Edge registers sample even while disabled so re-enabling sees no stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enter_q  <= 1'b1;
      r_select_q <= 1'b1;
    end else begin
      r_enter_q  <= enter;
      r_select_q <= select;
    end
  end

  assign w_ent = enable & r_enter_q & ~enter;
  assign w_sel = enable & r_select_q & ~select & ~w_ent;
  assign w_cpu = ~mode & (r_atk != 2'd0);

  assign w_rnd_x = (posicao_rnd[COORD_W-1:0] > MAXC) ?
                   MAXC : posicao_rnd[COORD_W-1:0];
  assign w_rnd_y = (posicao_rnd[2*COORD_W-1:COORD_W] > MAXC) ?
                   MAXC : posicao_rnd[2*COORD_W-1:COORD_W];

  always_comb begin
    w_life4 = '0;
    for (int i = 0; i < N_PLAYERS; i++)
      w_life4[i] = |qtd[i*LIFE_W +: LIFE_W];
  end

  always_comb begin
    w_alive = '0;
    for (int i = 0; i < 4; i++)
      w_alive = w_alive + {2'b00, w_life4[i]};
  end

  always_comb begin : next_atk
    logic [1:0] v_i;
    v_i        = r_atk;
    w_next_atk = r_atk;
    // Descending offset so the nearest living successor wins.
    for (int k = N_PLAYERS; k >= 1; k--) begin
      v_i = 2'((int'(r_atk) + k) % N_PLAYERS);
      if (w_life4[v_i]) w_next_atk = v_i;
    end
  end

  always_comb begin
    w_winner = r_atk;
    for (int i = N_PLAYERS - 1; i >= 0; i--)
      if (w_life4[i]) w_winner = 2'(i);
  end

`ifdef SHOT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to_cnt;
  logic          w_counting;

  assign w_counting = ~w_cpu &
                      ((r_state == ATK_X) | (r_state == ATK_Y));
  assign w_timeout  = enable & w_counting & ~w_ent & ~w_sel &
                      (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_to_cnt   <= '0;
      r_to_pulse <= 1'b0;
    end else begin
      r_to_pulse <= w_timeout;
      if (enable) begin
        if (!w_counting || w_ent || w_sel || w_timeout)
          r_to_cnt <= '0;
        else
          r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end
`else
  assign w_timeout = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_to_pulse <= 1'b0;
    else       r_to_pulse <= 1'b0;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ATK_X;
    else if (enable) r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (enable) begin
      unique case (r_state)
        ATK_X: begin
          if (w_cpu)          w_next_state = VERIF_ACERTO;
          else if (w_ent)     w_next_state = ATK_Y;
          else if (w_timeout) w_next_state = NEXT_TURN;
        end
        ATK_Y: begin
          if (w_ent)          w_next_state = VERIF_ACERTO;
          else if (w_timeout) w_next_state = NEXT_TURN;
        end
        VERIF_ACERTO: begin
          if (w_ent)
            w_next_state = acertou_tiro ? VERIF_VIDA : NEXT_TURN;
        end
        VERIF_VIDA: begin
          if (w_ent)
            w_next_state = (w_alive <= 3'd1) ? VENCEDOR : NEXT_TURN;
        end
        NEXT_TURN: w_next_state = ATK_X;
        VENCEDOR:  w_next_state = END_GAME;
        END_GAME:  w_next_state = END_GAME;
        default:   w_next_state = ATK_X;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x    <= '0;
      r_y    <= '0;
      r_atk  <= 2'd0;
      r_win  <= 2'd0;
      r_miss <= 1'b0;
    end else if (enable) begin
      if (r_state != VERIF_ACERTO && w_next_state == VERIF_ACERTO)
        r_miss <= 1'b0;
      case (r_state)
        ATK_X: begin
          if (w_cpu) begin
            r_x <= w_rnd_x;
            r_y <= w_rnd_y;
          end else if (w_sel) begin
            r_x <= f_inc(r_x);
          end
        end
        ATK_Y: begin
          if (w_sel) r_y <= f_inc(r_y);
        end
        VERIF_ACERTO: begin
          if (w_ent && !acertou_tiro) r_miss <= 1'b1;
        end
        NEXT_TURN: begin
          r_atk <= w_next_atk;
          r_x   <= '0;
          r_y   <= '0;
        end
        VENCEDOR: r_win <= w_winner;
        default: ;
      endcase
    end
  end

  assign coord_tiroX = r_x;
  assign coord_tiroY = r_y;
  assign atacante    = r_atk;
  assign vencedor    = r_win;

  always_comb begin
    ready = (r_state == VERIF_ACERTO);
    LEDG  = '0;
    LEDG[3:0] = 4'b0001 << r_atk;
    LEDG[7]   = (r_state == VENCEDOR) | (r_state == END_GAME);
    LEDR  = '0;
    LEDR[N_PLAYERS-1:0] = ~w_life4[N_PLAYERS-1:0];
    LEDR[6] = r_to_pulse;
    LEDR[7] = r_miss;
  end

endmodule
